// File: rtl/bcd_counter_chain_if.sv
// Control and display bundle between the BCD counter chain and its driver.
// The master drives clear/load/count requests; the slave returns the count and its pulses.
interface bcd_counter_chain_if #(
  parameter int DIGITS = 4
);
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  en;
  logic                  up_dn;
  logic [4*DIGITS-1:0]   q;
  logic [DIGITS-1:0]     digit_tick;
  logic                  carry;
  logic                  sat;
  logic                  load_err;

  modport master (
    output clr, load, load_val, en, up_dn,
    input  q, digit_tick, carry, sat, load_err
  );

  modport slave (
    input  clr, load, load_val, en, up_dn,
    output q, digit_tick, carry, sat, load_err
  );
endinterface

// File: rtl/bcd_counter_chain.sv
// Cascaded up/down BCD counter with clamped load, clear, wrap or saturate at terminal count.
// q and all pulse outputs update on the edge that samples clr/load/en; no backpressure.
module bcd_counter_chain #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  bcd_counter_chain_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0]      q_q, q_d;
  logic [DIGITS-1:0] tick_q, tick_d;
  logic              carry_q, carry_d;
  logic              sat_q, sat_d;
  logic              err_q, err_d;

  logic [W-1:0]      step_val;
  logic [DIGITS-1:0] step_tick;
  logic              run_term;
  logic [3:0]        cur;
  logic [3:0]        lv;

  // run_term is high while every lower digit sits at its terminal value; after the loop it
  // means the whole chain is at terminal count for the requested direction.
  always_comb begin
    step_val  = q_q;
    step_tick = '0;
    run_term  = 1'b1;
    cur       = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      cur = q_q[4*i +: 4];
      if (run_term) begin
        if (bus.up_dn) begin
          if (cur == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
            step_tick[i]       = 1'b1;
          end else begin
            step_val[4*i +: 4] = cur + 4'd1;
          end
        end else begin
          if (cur == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
            step_tick[i]       = 1'b1;
          end else begin
            step_val[4*i +: 4] = cur - 4'd1;
          end
        end
      end
      run_term = run_term & (cur == (bus.up_dn ? 4'd9 : 4'd0));
    end
  end

  always_comb begin
    q_d     = q_q;
    tick_d  = '0;
    carry_d = 1'b0;
    sat_d   = sat_q;
    err_d   = 1'b0;
    lv      = 4'd0;
    if (bus.clr) begin
      q_d   = '0;
      sat_d = 1'b0;
    end else if (bus.load) begin
      for (int i = 0; i < DIGITS; i++) begin
        lv = bus.load_val[4*i +: 4];
        if (lv > 4'd9) begin
          q_d[4*i +: 4] = 4'd9;
          err_d         = 1'b1;
        end else begin
          q_d[4*i +: 4] = lv;
        end
      end
      sat_d = 1'b0;
    end else if (bus.en) begin
      if (run_term && !WRAP) begin
        // Holding at terminal: carry only marks the first blocked step.
        sat_d   = 1'b1;
        carry_d = ~sat_q;
      end else begin
        q_d     = step_val;
        tick_d  = step_tick;
        carry_d = run_term;
        sat_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q     <= '0;
      tick_q  <= '0;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign bus.q          = q_q;
  assign bus.digit_tick = tick_q;
  assign bus.carry      = carry_q;
  assign bus.sat        = sat_q;
  assign bus.load_err   = err_q;
endmodule
